// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if
//   Bundles the fetch stage's control inputs, instruction-ROM bus and IF/ID
//   pipeline register outputs.
//   master : the fetch unit (drives ce, pc and the IF/ID fields)
//   slave  : the environment (hazard controller, ID stage, ROM, decode)
//   Signals:
//     stall_if, stall_id        hazard-controller stalls
//     branch_flag/target        taken branch/jump redirect from ID
//     flush/flush_pc            exception/eret redirect
//     inst_i                    word returned by the combinational ROM
//     ce, pc                    ROM chip enable and byte address (registered)
//     if_id_pc/inst/valid       IF/ID pipeline register contents
interface pc_fetch_unit_if;
    logic        stall_if;
    logic        stall_id;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] inst_i;
    logic        ce;
    logic [31:0] pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_valid;

    modport master (
        input  stall_if, stall_id, branch_flag, branch_target, flush, flush_pc, inst_i,
        output ce, pc, if_id_pc, if_id_inst, if_id_valid
    );

    modport slave (
        output stall_if, stall_id, branch_flag, branch_target, flush, flush_pc, inst_i,
        input  ce, pc, if_id_pc, if_id_inst, if_id_valid
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Instruction-fetch stage of the five-stage MIPS pipeline. Holds the PC,
//   drives the ROM chip enable/address and captures the returned word with
//   its PC into the IF/ID register. Handles sequential increment, branch
//   redirect, exception flush and per-stage stalls.
//   Ports:
//     clk  pipeline clock, rising edge
//     rst  asynchronous active-high reset
//     fif  pc_fetch_unit_if.master (controls, ROM bus, IF/ID outputs)
//   All outputs come straight from flops.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    pc_fetch_unit_if.master    fif
);

    localparam logic [31:0] AlignMask = 32'hFFFF_FFFC;

    logic        ce_q;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] id_pc_q,    id_pc_d;
    logic [31:0] id_inst_q,  id_inst_d;
    logic        id_valid_q, id_valid_d;

    // PC stays at RESET_PC until ce has risen, so the first fetch is RESET_PC.
    always_comb begin
        pc_d = pc_q;
        if (ce_q) begin
            if (fif.flush) begin
                pc_d = fif.flush_pc & AlignMask;
            end else if (fif.stall_if) begin
                // A branch seen while stalled is dropped; ID re-asserts it.
                pc_d = pc_q;
            end else if (fif.branch_flag) begin
                pc_d = fif.branch_target & AlignMask;
            end else begin
                pc_d = pc_q + 32'(PC_STEP);
            end
        end
    end

    // Branches do not squash IF/ID: the delay-slot word is captured normally.
    always_comb begin
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        if (fif.flush || (fif.stall_if && !fif.stall_id)) begin
            id_pc_d    = '0;
            id_inst_d  = '0;
            id_valid_d = 1'b0;
        end else if (fif.stall_id) begin
            // Covers the legal stall_if&stall_id case and the illegal
            // stall_id-only case alike: hold.
            id_pc_d    = id_pc_q;
            id_inst_d  = id_inst_q;
            id_valid_d = id_valid_q;
        end else if (!ce_q) begin
            id_pc_d    = '0;
            id_inst_d  = '0;
            id_valid_d = 1'b0;
        end else begin
            id_pc_d    = pc_q;
            id_inst_d  = fif.inst_i;
            id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_q       <= 1'b0;
            pc_q       <= RESET_PC;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
            id_valid_q <= 1'b0;
        end else begin
            ce_q       <= 1'b1;
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign fif.ce          = ce_q;
    assign fif.pc          = pc_q;
    assign fif.if_id_pc    = id_pc_q;
    assign fif.if_id_inst  = id_inst_q;
    assign fif.if_id_valid = id_valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } id_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    id_t  sb[$];

    pc_fetch_unit_if bus();

    pc_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fif (bus.master)
    );

    // ROM contents: a distinct, nonzero word per address.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    assign bus.inst_i = rom(bus.pc);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_id(input string tag);
        id_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s got=empty exp=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".id_pc"}, bus.if_id_pc, e.pc);
            chk({tag, ".id_inst"}, bus.if_id_inst, e.inst);
            chk({tag, ".id_valid"}, {31'b0, bus.if_id_valid}, {31'b0, e.valid});
        end
    endtask

    // One clock: push expected IF/ID, clock, check pc/ce and pop IF/ID.
    task automatic cycle(input string tag, input logic [31:0] exp_pc, input logic exp_v,
                         input logic [31:0] exp_id_pc, input logic exp_ce = 1'b1);
        id_t e;
        e.pc    = exp_v ? exp_id_pc : 32'h0;
        e.inst  = exp_v ? rom(exp_id_pc) : 32'h0;
        e.valid = exp_v;
        sb.push_back(e);
        @(posedge clk);
        #1;
        chk({tag, ".ce"}, {31'b0, bus.ce}, {31'b0, exp_ce});
        chk({tag, ".pc"}, bus.pc, exp_pc);
        chk_id(tag);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".ce"}, {31'b0, bus.ce}, 32'h0);
        chk({tag, ".pc"}, bus.pc, 32'h0);
        chk({tag, ".id_pc"}, bus.if_id_pc, 32'h0);
        chk({tag, ".id_inst"}, bus.if_id_inst, 32'h0);
        chk({tag, ".id_valid"}, {31'b0, bus.if_id_valid}, 32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.stall_if      = 1'b0;
        bus.stall_id      = 1'b0;
        bus.branch_flag   = 1'b0;
        bus.branch_target = 32'h0;
        bus.flush         = 1'b0;
        bus.flush_pc      = 32'h0;

        // Reset held across edges.
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;

        // Sequential run: pc 0,0,4,8; IF/ID one behind.
        cycle("run0", 32'h0, 1'b0, 32'h0);
        cycle("run1", 32'h4, 1'b1, 32'h0);
        cycle("run2", 32'h8, 1'b1, 32'h4);

        // Branch at pc=8: delay slot captured, then target.
        bus.branch_flag   = 1'b1;
        bus.branch_target = 32'h40;
        cycle("br0", 32'h40, 1'b1, 32'h8);
        bus.branch_flag   = 1'b0;
        cycle("br1", 32'h44, 1'b1, 32'h40);

        // stall_if only: pc holds, IF/ID bubbles, then resumes.
        bus.stall_if = 1'b1;
        cycle("stif0", 32'h44, 1'b0, 32'h0);
        cycle("stif1", 32'h44, 1'b0, 32'h0);
        bus.stall_if = 1'b0;
        cycle("stif2", 32'h48, 1'b1, 32'h44);

        // stall_if+stall_id: IF/ID holds; branch during stall is dropped.
        bus.stall_if = 1'b1;
        bus.stall_id = 1'b1;
        cycle("stid0", 32'h48, 1'b1, 32'h44);
        bus.branch_flag   = 1'b1;
        bus.branch_target = 32'h80;
        cycle("stid1", 32'h48, 1'b1, 32'h44);
        bus.branch_flag = 1'b0;
        bus.stall_if    = 1'b0;
        bus.stall_id    = 1'b0;
        cycle("stid2", 32'h4C, 1'b1, 32'h48);

        // Flush beats stall and branch; unaligned target is aligned.
        bus.flush         = 1'b1;
        bus.flush_pc      = 32'h183;
        bus.stall_if      = 1'b1;
        bus.branch_flag   = 1'b1;
        bus.branch_target = 32'h40;
        cycle("fl0", 32'h180, 1'b0, 32'h0);
        bus.flush       = 1'b0;
        bus.stall_if    = 1'b0;
        bus.branch_flag = 1'b0;
        cycle("fl1", 32'h184, 1'b1, 32'h180);

        // Wrap at top of address space.
        bus.branch_flag   = 1'b1;
        bus.branch_target = 32'hFFFF_FFFC;
        cycle("wr0", 32'hFFFF_FFFC, 1'b1, 32'h184);
        bus.branch_flag = 1'b0;
        cycle("wr1", 32'h0, 1'b1, 32'hFFFF_FFFC);
        total++;
        assert (!$isunknown(bus.pc)) else begin
            bad++;
            $error("FAIL wr.noX got=%h exp=known", bus.pc);
        end
        cycle("wr2", 32'h4, 1'b1, 32'h0);

        // Async reset between edges during a stall.
        bus.stall_if = 1'b1;
        bus.stall_id = 1'b1;
        cycle("ar0", 32'h4, 1'b1, 32'h0);
        #3;
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        @(posedge clk);
        #1;
        chk_reset("async_hold");
        rst = 1'b0;
        bus.stall_if = 1'b0;
        bus.stall_id = 1'b0;
        cycle("rs0", 32'h0, 1'b0, 32'h0);
        cycle("rs1", 32'h4, 1'b1, 32'h0);
        cycle("rs2", 32'h8, 1'b1, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline. It holds the program counter and drives the chip-enable and address of the combinational instruction ROM. It captures the ROM's returned word, together with its PC, into the IF/ID pipeline register. It handles sequential increment, branch/jump redirect from ID, exception flush, and per-stage stall from the hazard controller.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `PC_STEP`, 4, byte increment per sequential fetch

Ports:
- `clk`  in  1  pipeline clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `stall_if`  in  1  hold PC (from hazard controller)
- `stall_id`  in  1  hold ID stage
- `branch_flag`  in  1  taken branch/jump resolved in ID
- `branch_target`  in  32  redirect byte address
- `flush`  in  1  exception/eret redirect
- `flush_pc`  in  32  handler or return byte address
- `inst_i`  in  32  word returned by instruction ROM
- `ce`  out  1  ROM chip enable (registered)
- `pc`  out  32  ROM byte address (registered)
- `if_id_pc`  out  32  PC of the instruction held in IF/ID
- `if_id_inst`  out  32  instruction handed to decode
- `if_id_valid`  out  1  IF/ID holds a real instruction

## Operation
- Reset (async, any time, including mid-operation):
  - `ce`=0, `pc`=`RESET_PC`
  - `if_id_pc`=0, `if_id_inst`=0, `if_id_valid`=0
- `ce` goes 1 on the first edge after `rst` deasserts and then stays 1 until the next reset.
- While `ce`=0, `pc` holds `RESET_PC`. The first fetched address is therefore `RESET_PC`.
- PC next-state priority, evaluated only when `ce`=1:
  1. `flush` → `flush_pc`
  2. `stall_if` → hold
  3. `branch_flag` → `branch_target`
  4. else `pc`+`PC_STEP`
- Targets are word-aligned by forcing bits [1:0] to 0.
- Increment is modulo 2^32: 32'hFFFF_FFFC → 32'h0000_0000.
- A `branch_flag` that arrives while `stall_if`=1 is not retained. ID holds the branch and re-asserts the flag.
- IF/ID update, in priority order:
  - `flush`: load a bubble (inst=0, pc=0, valid=0).
  - `stall_if`=1 and `stall_id`=0: load a bubble.
  - `stall_if`=1 and `stall_id`=1: hold all fields.
  - `stall_if`=0, `stall_id`=0, `ce`=0: load a bubble.
  - `stall_if`=0, `stall_id`=0, `ce`=1: capture `pc`, `inst_i`, and set valid=1.
- `stall_id`=1 with `stall_if`=0 is illegal from the controller. Treat it as hold.
- Delay slot: `branch_flag` does not squash IF/ID. The instruction fetched in the redirect cycle (the delay slot) is captured normally.
- `inst_i` is sampled only at the clock edge. The ROM is combinational, so `inst_i` corresponds to the current `pc`.

## Timing
- Fetch latency: the word at address A appears on `if_id_inst` one edge after `pc`=A.
- Redirect latency:
  - `branch_flag` or `flush` high at edge N sets `pc` to the target after edge N.
  - The target instruction reaches IF/ID after edge N+1.
- After reset release, the first valid IF/ID (pc=`RESET_PC`) appears after the second rising edge.
- Throughput: one instruction per cycle when unstalled.
- `flush` and `stall_if` together: flush wins. PC is redirected and IF/ID is bubbled.
- `flush` and `branch_flag` together: flush wins.
- All outputs are registered, with no combinational input-to-output path.

## Test plan
- Reset then run, ROM loaded with words at 0,4,8:
  - `ce` is 0 during reset and 1 after the first edge.
  - `pc` follows 0,0,4,8.
  - `if_id_pc`/`if_id_inst` show 0/word0 one cycle behind `pc`, with valid=1.
- Branch: `branch_flag`=1, `branch_target`=32'h40 when `pc`=8:
  - IF/ID captures inst@8 as the delay slot.
  - `pc` becomes 32'h40.
  - Next, IF/ID shows pc=32'h40.
- Stall: `stall_if`=1, `stall_id`=0 for 2 cycles at `pc`=12:
  - `pc` holds 12.
  - IF/ID is a bubble (inst=0, valid=0) for 2 cycles, then pc=12 is captured.
  - Repeat with `stall_id`=1: IF/ID holds its prior contents.
- Flush with simultaneous stall and branch: `flush_pc`=32'h180, `branch_target`=32'h40:
  - `pc` becomes 32'h180.
  - IF/ID is a bubble.
  - Unaligned 32'h183 yields `pc`=32'h180.
- Wrap: force `branch_target`=32'hFFFF_FFFC → next `pc`=0, no X.
- Async reset mid-stall:
  - Assert `rst` between edges → all outputs return to reset values immediately.
  - Fetch restarts at `RESET_PC`.
